// File: rtl/sodor_mem_pkg.sv
// Shared definitions for the Sodor scratchpad memory: access-type and
// function codes, dmem FSM states, byte-mask type and the byte-merge helper.
package sodor_mem_pkg;

    // Access widths as encoded on dmem_req_bits_typ.
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    // Memory function codes as encoded on dmem_req_bits_fcn.
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    // Data-port sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // One enable bit per byte lane of a 32-bit word.
    typedef logic [3:0] byte_mask_t;

    // Request fields held for the lifetime of one dmem transaction.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fcn;
        logic [2:0]  typ;
    } dmem_req_t;

    // Replace the masked byte lanes of old_w with those of new_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input byte_mask_t  mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spm_lane_align.sv
// Lane alignment for the scratchpad: extracts and extends load data from a
// stored word, and replicates store data with its byte-enable mask.
module spm_lane_align
    import sodor_mem_pkg::*;
(
    input  logic [2:0]  typ_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o,
    output byte_mask_t  mask_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword; halfword selection looks at lane bit 1 only.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (lane_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Sign- or zero-extend the selected field into the architectural load value.
    always_comb begin
        load_o = '0;
        case (typ_i)
            MT_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            MT_BU:   load_o = {24'd0, byte_sel};
            MT_H:    load_o = {{16{half_sel[15]}}, half_sel};
            MT_HU:   load_o = {16'd0, half_sel};
            MT_W:    load_o = rdata_i;
            default: load_o = '0;
        endcase
    end

    // Replicate right-justified store data across the word and enable only the addressed lanes.
    always_comb begin
        store_o = wdata_i;
        mask_o  = 4'b0000;
        case (typ_i)
            MT_B: begin
                store_o = {4{wdata_i[7:0]}};
                mask_o  = 4'b0001 << lane_i;
            end
            MT_H: begin
                store_o = {2{wdata_i[15:0]}};
                mask_o  = lane_i[1] ? 4'b1100 : 4'b0011;
            end
            MT_W: begin
                store_o = wdata_i;
                mask_o  = 4'b1111;
            end
            default: begin
                store_o = wdata_i;
                mask_o  = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/sodor_scratchpad_mem.sv
// Scratchpad memory serving the Sodor 5-stage core: a one-cycle pipelined
// instruction fetch port and a data port with DMEM_WAIT programmable wait
// states. Optional macro SCRATCHPAD_IMEM_FWD_EN forwards a same-cycle store
// into the fetch result (post-write data) instead of read-before-write.
module sodor_scratchpad_mem
    import sodor_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int DMEM_WAIT   = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_req_valid,
    input  logic [31:0] imem_req_bits_addr,
    output logic        imem_resp_valid,
    output logic [31:0] imem_resp_bits_data,
    input  logic        dmem_req_valid,
    input  logic [31:0] dmem_req_bits_addr,
    input  logic [31:0] dmem_req_bits_data,
    input  logic        dmem_req_bits_fcn,
    input  logic [2:0]  dmem_req_bits_typ,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_bits_data
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(DMEM_WAIT);

    // Word storage; contents survive reset.
    logic [31:0] mem_q [DEPTH_WORDS];

    // Fetch pipeline register.
    logic              imem_valid_q;
    logic [31:0]       imem_data_q;
    logic [31:0]       imem_data_d;
    logic [IDX_W-1:0]  imem_idx;

    // Data-port sequencing.
    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic [IDX_W-1:0]  dm_idx;
    logic [31:0]       dm_rword;
    logic [31:0]       dm_load;
    logic [31:0]       dm_store_word;
    byte_mask_t        dm_mask;
    logic              store_fire;

    // Upper address bits alias; low fetch bits are ignored because fetches are word-wide.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_req_bits_addr[31:IDX_W+2], imem_req_bits_addr[1:0],
                                req_q.addr[31:IDX_W+2]};

    assign imem_idx = imem_req_bits_addr[IDX_W+1:2];
    assign dm_idx   = req_q.addr[IDX_W+1:2];
    assign dm_rword = mem_q[dm_idx];

    spm_lane_align u_align (
        .typ_i   (req_q.typ),
        .lane_i  (req_q.addr[1:0]),
        .rdata_i (dm_rword),
        .wdata_i (req_q.data),
        .load_o  (dm_load),
        .store_o (dm_store_word),
        .mask_o  (dm_mask)
    );

    // Fetch data source: array word, or the merged store word when forwarding a same-cycle store.
    always_comb begin
        imem_data_d = mem_q[imem_idx];
`ifdef SCRATCHPAD_IMEM_FWD_EN
        if (store_fire && (imem_idx == dm_idx)) begin
            imem_data_d = merge_bytes(dm_rword, dm_store_word, dm_mask);
        end
`endif
    end

    // Fetch response register: one-cycle latency, accepts a new fetch every cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_valid_q <= 1'b0;
            imem_data_q  <= '0;
        end else begin
            imem_valid_q <= imem_req_valid;
            imem_data_q  <= imem_data_d;
        end
    end

    assign imem_resp_valid     = imem_valid_q;
    assign imem_resp_bits_data = imem_data_q;

    // Data-port state register with captured request and wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Next-state logic: capture in IDLE, count down wait states, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (dmem_req_valid) begin
                    req_d.addr = dmem_req_bits_addr;
                    req_d.data = dmem_req_bits_data;
                    req_d.fcn  = dmem_req_bits_fcn;
                    req_d.typ  = dmem_req_bits_typ;
                    if (DMEM_WAIT == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: response pulse, formatted load data, and the store strobe.
    always_comb begin
        dmem_resp_valid     = 1'b0;
        dmem_resp_bits_data = '0;
        store_fire          = 1'b0;
        if (state_q == RESP) begin
            dmem_resp_valid = 1'b1;
            if (req_q.fcn == M_XRD) begin
                dmem_resp_bits_data = dm_load;
            end else begin
                store_fire = 1'b1;
            end
        end
    end

    // Array write: only in the RESP cycle, so each store request writes exactly once.
    always_ff @(posedge clock) begin
        if (store_fire) begin
            mem_q[dm_idx] <= merge_bytes(dm_rword, dm_store_word, dm_mask);
        end
    end

endmodule

// File: tb/tb_sodor_scratchpad_mem.sv
module tb_sodor_scratchpad_mem;

    localparam int WAITS = 2;
    localparam int LAT   = 1 + WAITS;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid = 1'b0;
    logic [31:0] imem_req_bits_addr = '0;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_bits_data;
    logic        dmem_req_valid = 1'b0;
    logic [31:0] dmem_req_bits_addr = '0;
    logic [31:0] dmem_req_bits_data = '0;
    logic        dmem_req_bits_fcn = 1'b0;
    logic [2:0]  dmem_req_bits_typ = 3'd0;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_bits_data;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Behavioural image of the array, indexed by word (addresses stay below 16 KiB).
    logic [31:0] ref_mem [4096];

    sodor_scratchpad_mem #(.DEPTH_WORDS(4096), .DMEM_WAIT(WAITS)) dut (
        .clock               (clock),
        .reset               (reset),
        .imem_req_valid      (imem_req_valid),
        .imem_req_bits_addr  (imem_req_bits_addr),
        .imem_resp_valid     (imem_resp_valid),
        .imem_resp_bits_data (imem_resp_bits_data),
        .dmem_req_valid      (dmem_req_valid),
        .dmem_req_bits_addr  (dmem_req_bits_addr),
        .dmem_req_bits_data  (dmem_req_bits_data),
        .dmem_req_bits_fcn   (dmem_req_bits_fcn),
        .dmem_req_bits_typ   (dmem_req_bits_typ),
        .dmem_resp_valid     (dmem_resp_valid),
        .dmem_resp_bits_data (dmem_resp_bits_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] typ,
                                               input logic [1:0] lane);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lane)) & 32'h0000_00FF;
        h = (w >> (16 * lane[1])) & 32'h0000_FFFF;
        case (typ)
            3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd5: return b;
            3'd2: return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd6: return h;
            3'd3: return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old_w, input logic [2:0] typ,
                                                input logic [1:0] lane, input logic [31:0] d);
        int sh;
        case (typ)
            3'd1: begin
                sh = 8 * lane;
                return (old_w & ~(32'h0000_00FF << sh)) | ((d & 32'h0000_00FF) << sh);
            end
            3'd2: begin
                sh = 16 * lane[1];
                return (old_w & ~(32'h0000_FFFF << sh)) | ((d & 32'h0000_FFFF) << sh);
            end
            3'd3: return d;
            default: return old_w;
        endcase
    endfunction

    // Drives one held request from a negedge; returns data, cycles to response and
    // the response-valid level one cycle after the response.
    task automatic dmem_op(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] rdata,
                           output int lat, output logic extra);
        dmem_req_valid     = 1'b1;
        dmem_req_bits_fcn  = fcn;
        dmem_req_bits_typ  = typ;
        dmem_req_bits_addr = addr;
        dmem_req_bits_data = data;
        lat   = -1;
        rdata = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (dmem_resp_valid) begin
                lat   = i;
                rdata = dmem_resp_bits_data;
                break;
            end
        end
        dmem_req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        extra = dmem_resp_valid;
        if (fcn) begin
            ref_mem[addr[13:2]] = model_store(ref_mem[addr[13:2]], typ, addr[1:0], data);
        end
    endtask

    task automatic test_reset();
        imem_req_valid = 1'b1;
        imem_req_bits_addr = 32'h10;
        dmem_req_valid = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_cnt++;
        if (imem_resp_valid !== 1'b0) $display("FAIL reset_imem_valid got %h exp 0", imem_resp_valid);
        else pass_cnt++;
        chk_cnt++;
        if (imem_resp_bits_data !== 32'd0) $display("FAIL reset_imem_data got %h exp 0", imem_resp_bits_data);
        else pass_cnt++;
        chk_cnt++;
        if (dmem_resp_valid !== 1'b0) $display("FAIL reset_dmem_valid got %h exp 0", dmem_resp_valid);
        else pass_cnt++;
        chk_cnt++;
        if (dmem_resp_bits_data !== 32'd0) $display("FAIL reset_dmem_data got %h exp 0", dmem_resp_bits_data);
        else pass_cnt++;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_preload();
        logic [31:0] rd;
        int lat;
        logic ex;
        logic [31:0] addrs [6] = '{32'h10, 32'h14, 32'h200, 32'h300, 32'h40, 32'h80};
        logic [31:0] vals  [6] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h80FF7F01,
                                   32'hAAAAAAAA, 32'h11111111, 32'h00000013};
        for (int i = 0; i < 6; i++) begin
            dmem_op(1'b1, 3'd3, addrs[i], vals[i], rd, lat, ex);
            chk_cnt++;
            if (lat !== LAT || ex !== 1'b0 || rd !== 32'd0)
                $display("FAIL preload_sw got lat=%0d extra=%0d data=%h exp lat=%0d extra=0 data=0",
                         lat, ex, rd, LAT);
            else pass_cnt++;
        end
    endtask

    task automatic test_dmem_wait();
        logic [31:0] rd;
        int lat;
        logic ex;
        dmem_op(1'b1, 3'd3, 32'h100, 32'h12345678, rd, lat, ex);
        chk_cnt++;
        if (lat !== LAT || ex !== 1'b0) $display("FAIL sw_latency got %0d/%0d exp %0d/0", lat, ex, LAT);
        else pass_cnt++;
        dmem_op(1'b0, 3'd3, 32'h100, 32'h0, rd, lat, ex);
        chk_cnt++;
        if (lat !== LAT || ex !== 1'b0) $display("FAIL lw_latency got %0d/%0d exp %0d/0", lat, ex, LAT);
        else pass_cnt++;
        chk_cnt++;
        if (rd !== 32'h12345678) $display("FAIL lw_data got %h exp 12345678", rd);
        else pass_cnt++;
    endtask

    task automatic test_imem();
        @(negedge clock);
        imem_req_valid = 1'b1;
        imem_req_bits_addr = 32'h10;
        @(negedge clock);
        chk_cnt++;
        if (imem_resp_valid !== 1'b1 || imem_resp_bits_data !== 32'hDEADBEEF)
            $display("FAIL fetch_10 got %0d/%h exp 1/deadbeef", imem_resp_valid, imem_resp_bits_data);
        else pass_cnt++;
        imem_req_bits_addr = 32'h14;
        @(negedge clock);
        chk_cnt++;
        if (imem_resp_valid !== 1'b1 || imem_resp_bits_data !== 32'hCAFEF00D)
            $display("FAIL fetch_14 got %0d/%h exp 1/cafef00d", imem_resp_valid, imem_resp_bits_data);
        else pass_cnt++;
        imem_req_valid = 1'b0;
        @(negedge clock);
        chk_cnt++;
        if (imem_resp_valid !== 1'b0) $display("FAIL fetch_idle got %0d exp 0", imem_resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_load_ext();
        logic [31:0] rd;
        int lat;
        logic ex;
        logic [2:0]  typs [4] = '{3'd1, 3'd5, 3'd2, 3'd6};
        logic [31:0] adrs [4] = '{32'h203, 32'h203, 32'h202, 32'h200};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        for (int i = 0; i < 4; i++) begin
            dmem_op(1'b0, typs[i], adrs[i], 32'h0, rd, lat, ex);
            chk_cnt++;
            if (rd !== exps[i] || lat !== LAT)
                $display("FAIL load_ext typ=%0d got %h lat=%0d exp %h lat=%0d", typs[i], rd, lat, exps[i], LAT);
            else pass_cnt++;
        end
    endtask

    task automatic test_store_merge();
        logic [31:0] rd;
        int lat;
        logic ex;
        dmem_op(1'b1, 3'd1, 32'h301, 32'h00000055, rd, lat, ex);
        dmem_op(1'b0, 3'd3, 32'h300, 32'h0, rd, lat, ex);
        chk_cnt++;
        if (rd !== 32'hAAAA55AA) $display("FAIL store_sb got %h exp aaaa55aa", rd);
        else pass_cnt++;
        dmem_op(1'b1, 3'd2, 32'h302, 32'h00001234, rd, lat, ex);
        dmem_op(1'b0, 3'd3, 32'h300, 32'h0, rd, lat, ex);
        chk_cnt++;
        if (rd !== 32'h123455AA) $display("FAIL store_sh got %h exp 123455aa", rd);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd;
        int lat;
        logic ex;
        logic seen;
        dmem_req_valid     = 1'b1;
        dmem_req_bits_fcn  = 1'b1;
        dmem_req_bits_typ  = 3'd3;
        dmem_req_bits_addr = 32'h40;
        dmem_req_bits_data = 32'hFFFFFFFF;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        dmem_req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (dmem_resp_valid) seen = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (dmem_resp_valid) seen = 1'b1;
        end
        chk_cnt++;
        if (seen !== 1'b0) $display("FAIL midreset_resp got %0d exp 0", seen);
        else pass_cnt++;
        dmem_op(1'b0, 3'd3, 32'h40, 32'h0, rd, lat, ex);
        chk_cnt++;
        if (rd !== 32'h11111111) $display("FAIL midreset_word got %h exp 11111111", rd);
        else pass_cnt++;
        chk_cnt++;
        if (lat !== LAT) $display("FAIL midreset_idle_lat got %0d exp %0d", lat, LAT);
        else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_w;
        logic hit;
`ifdef SCRATCHPAD_IMEM_FWD_EN
        exp_w = 32'h0000006F;
`else
        exp_w = 32'h00000013;
`endif
        dmem_req_valid     = 1'b1;
        dmem_req_bits_fcn  = 1'b1;
        dmem_req_bits_typ  = 3'd3;
        dmem_req_bits_addr = 32'h80;
        dmem_req_bits_data = 32'h0000006F;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (dmem_resp_valid) begin
                hit = 1'b1;
                break;
            end
        end
        imem_req_valid = 1'b1;
        imem_req_bits_addr = 32'h80;
        @(negedge clock);
        dmem_req_valid = 1'b0;
        imem_req_valid = 1'b0;
        ref_mem[32] = 32'h0000006F;
        chk_cnt++;
        if (hit !== 1'b1 || imem_resp_bits_data !== exp_w)
            $display("FAIL same_cycle_fetch got resp=%0d data=%h exp resp=1 data=%h", hit, imem_resp_bits_data, exp_w);
        else pass_cnt++;
        @(negedge clock);
        imem_req_valid = 1'b1;
        @(negedge clock);
        imem_req_valid = 1'b0;
        chk_cnt++;
        if (imem_resp_bits_data !== 32'h0000006F)
            $display("FAIL after_store_fetch got %h exp 0000006f", imem_resp_bits_data);
        else pass_cnt++;
    endtask

    task automatic test_random_dmem();
        logic [31:0] rd;
        int lat;
        logic ex;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
        logic [2:0]  ltyp [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        logic [2:0]  styp [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd7};
        logic [31:0] exp_d;
        for (int i = 0; i < 16; i++) begin
            dmem_op(1'b1, 3'd3, 32'h400 + 4 * i, $urandom, rd, lat, ex);
        end
        for (int i = 0; i < 60; i++) begin
            a = 32'h400 + $urandom_range(0, 63);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                t = styp[$urandom_range(0, 4)];
                dmem_op(1'b1, t, a, d, rd, lat, ex);
                chk_cnt++;
                if (rd !== 32'd0 || lat !== LAT || ex !== 1'b0)
                    $display("FAIL rand_store typ=%0d got data=%h lat=%0d extra=%0d exp 0/%0d/0", t, rd, lat, ex, LAT);
                else pass_cnt++;
            end else begin
                t = ltyp[$urandom_range(0, 4)];
                exp_d = model_load(ref_mem[a[13:2]], t, a[1:0]);
                dmem_op(1'b0, t, a, d, rd, lat, ex);
                chk_cnt++;
                if (rd !== exp_d || lat !== LAT || ex !== 1'b0)
                    $display("FAIL rand_load typ=%0d addr=%h got %h lat=%0d exp %h lat=%0d", t, a, rd, lat, exp_d, LAT);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_prev;
        logic [31:0] a;
        exp_prev = 32'd0;
        @(negedge clock);
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                chk_cnt++;
                if (imem_resp_valid !== 1'b1 || imem_resp_bits_data !== exp_prev)
                    $display("FAIL b2b_fetch %0d got %0d/%h exp 1/%h", i, imem_resp_valid, imem_resp_bits_data, exp_prev);
                else pass_cnt++;
            end
            if (i < 20) begin
                a = 32'h400 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                imem_req_valid = 1'b1;
                imem_req_bits_addr = a;
                exp_prev = ref_mem[a[13:2]];
                @(negedge clock);
            end
        end
        imem_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_preload();
        test_dmem_wait();
        test_imem();
        test_load_ext();
        test_store_merge();
        test_mid_reset();
        test_same_cycle();
        test_random_dmem();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
